mod_adder_pipe: RTL and testbench

Pipelined modular adder: joins two operand streams a and b (each < P) and emits (a + b) mod P on a single output stream. It is the additive counterpart of the modular subtractor pipeline and sits beside it in the field-arithmetic datapath. The carry chain is split across LEVEL register stages so that wide P still closes timing. Full ready/valid backpressure is supported at every stage.

---
 rtl/mod_adder_pipe_if.sv | 15 +
 rtl/mod_adder_pipe.sv | 135 +++++++++++++
 tb/tb_mod_adder_pipe.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/mod_adder_pipe_if.sv
// rtl/mod_adder_pipe_if.sv - operand join / result stream bundle for mod_adder_pipe
interface mod_adder_pipe_if #(
  parameter int C_DATA_WIDTH   = 32,
  parameter int C_NUM_CHANNELS = 2
);
  logic [C_NUM_CHANNELS-1:0]                   s_tvalid;
  logic [C_NUM_CHANNELS-1:0][C_DATA_WIDTH-1:0] s_tdata;
  logic [C_NUM_CHANNELS-1:0]                   s_tready;
  logic                                        m_tvalid;
  logic [C_DATA_WIDTH-1:0]                     m_tdata;
  logic                                        m_tready;

  modport master (output s_tvalid, s_tdata, m_tready, input s_tready, m_tvalid, m_tdata);
  modport slave  (input s_tvalid, s_tdata, m_tready, output s_tready, m_tvalid, m_tdata);
endinterface

// File: rtl/mod_adder_pipe.sv
// rtl/mod_adder_pipe.sv - pipelined (a + b) mod P with chunked carry chains; MOD_ADD_OUT_SKID_EN adds an output skid buffer
module mod_adder_pipe #(
  parameter int P              = 100,
  parameter int BITS           = $clog2(P),
  parameter int C_DATA_WIDTH   = 32,
  parameter int C_NUM_CHANNELS = 2,
  parameter int LEVEL          = 1
) (
  input  logic            aclk,
  input  logic            areset,
  mod_adder_pipe_if.slave bus
);
  localparam int W  = (BITS + LEVEL) / LEVEL;
  localparam int DW = LEVEL * W;
  localparam logic [DW-1:0] P_DW = DW'(P);
  localparam logic [DW-1:0] K    = ~P_DW + DW'(1);

  logic             val0;
  logic [LEVEL:0]   rdy;
  logic [LEVEL:1]   val_q, cs_q, cd_q;
  logic [DW-1:0]    a_q [1:LEVEL];
  logic [DW-1:0]    b_q [1:LEVEL];
  logic [DW-1:0]    s_q [1:LEVEL];
  logic [DW-1:0]    d_q [1:LEVEL];

  logic [DW-1:0]    a_in [LEVEL];
  logic [DW-1:0]    b_in [LEVEL];
  logic [DW-1:0]    s_in [LEVEL];
  logic [DW-1:0]    d_in [LEVEL];
  logic [LEVEL-1:0] v_in, cs_in, cd_in;

  logic [BITS-1:0]  res;
  logic             unused_ok;

  assign val0         = bus.s_tvalid[0] & bus.s_tvalid[1];
  assign bus.s_tready = {C_NUM_CHANNELS{rdy[0] & val0}};

  genvar g;
  for (g = 0; g < LEVEL; g++) begin : g_stage
    logic [W:0]    s_sum, d_sum;
    logic [DW-1:0] s_new, d_new;

    if (g == 0) begin : g_in
      assign a_in[g]  = DW'(bus.s_tdata[0][BITS-1:0]);
      assign b_in[g]  = DW'(bus.s_tdata[1][BITS-1:0]);
      assign s_in[g]  = '0;
      assign d_in[g]  = '0;
      assign v_in[g]  = val0;
      assign cs_in[g] = 1'b0;
      assign cd_in[g] = 1'b0;
    end else begin : g_mid
      assign a_in[g]  = a_q[g];
      assign b_in[g]  = b_q[g];
      assign s_in[g]  = s_q[g];
      assign d_in[g]  = d_q[g];
      assign v_in[g]  = val_q[g];
      assign cs_in[g] = cs_q[g];
      assign cd_in[g] = cd_q[g];
    end

    // d = s + K runs one chunk behind nothing: it consumes this stage's fresh s chunk
    assign s_sum = {1'b0, a_in[g][g*W +: W]} + {1'b0, b_in[g][g*W +: W]} + (W+1)'(cs_in[g]);
    assign d_sum = {1'b0, s_sum[W-1:0]} + {1'b0, K[g*W +: W]} + (W+1)'(cd_in[g]);

    always_comb begin
      s_new              = s_in[g];
      s_new[g*W +: W]    = s_sum[W-1:0];
      d_new              = d_in[g];
      d_new[g*W +: W]    = d_sum[W-1:0];
    end

    assign rdy[g] = ~val_q[g+1] | rdy[g+1];

    always_ff @(posedge aclk) begin
      if (areset) begin
        val_q[g+1] <= 1'b0;
        a_q[g+1]   <= '0;
        b_q[g+1]   <= '0;
        s_q[g+1]   <= '0;
        d_q[g+1]   <= '0;
        cs_q[g+1]  <= 1'b0;
        cd_q[g+1]  <= 1'b0;
      end else if (rdy[g]) begin
        val_q[g+1] <= v_in[g];
        if (v_in[g]) begin
          a_q[g+1]  <= a_in[g];
          b_q[g+1]  <= b_in[g];
          s_q[g+1]  <= s_new;
          d_q[g+1]  <= d_new;
          cs_q[g+1] <= s_sum[W];
          cd_q[g+1] <= d_sum[W];
        end
      end
    end
  end

  // top d-carry set means a + b >= P, so the offset sum is the reduced result
  assign res = cd_q[LEVEL] ? d_q[LEVEL][BITS-1:0] : s_q[LEVEL][BITS-1:0];

`ifdef MOD_ADD_OUT_SKID_EN
  logic [BITS-1:0] skid_mem [2];
  logic            skid_wp, skid_rp;
  logic [1:0]      skid_cnt;
  logic            skid_push, skid_pop;

  assign rdy[LEVEL]   = ~skid_cnt[1];
  assign skid_push    = val_q[LEVEL] & rdy[LEVEL];
  assign bus.m_tvalid = |skid_cnt;
  assign skid_pop     = bus.m_tvalid & bus.m_tready;
  assign bus.m_tdata  = C_DATA_WIDTH'(skid_mem[skid_rp]);

  always_ff @(posedge aclk) begin
    if (areset) begin
      skid_mem[0] <= '0;
      skid_mem[1] <= '0;
      skid_wp     <= 1'b0;
      skid_rp     <= 1'b0;
      skid_cnt    <= 2'd0;
    end else begin
      if (skid_push) begin
        skid_mem[skid_wp] <= res;
        skid_wp           <= ~skid_wp;
      end
      if (skid_pop) skid_rp <= ~skid_rp;
      skid_cnt <= skid_cnt + 2'(skid_push) - 2'(skid_pop);
    end
  end
`else
  assign rdy[LEVEL]   = bus.m_tready;
  assign bus.m_tvalid = val_q[LEVEL];
  assign bus.m_tdata  = C_DATA_WIDTH'(res);
`endif

  assign unused_ok = ^{a_q[LEVEL], b_q[LEVEL], cs_q[LEVEL], s_q[LEVEL], d_q[LEVEL], bus.s_tdata};
endmodule

// File: tb/tb_mod_adder_pipe.sv
// tb/tb_mod_adder_pipe.sv - directed bench for mod_adder_pipe at P=100, LEVEL=1..3
module tb_mod_adder_pipe;
  localparam int P = 100;
`ifdef MOD_ADD_OUT_SKID_EN
  localparam int SK = 1;
`else
  localparam int SK = 0;
`endif

  logic aclk = 1'b0;
  logic areset = 1'b1;
  always #5 aclk = ~aclk;

  logic [1:0]  tv  [3];
  logic [31:0] ta  [3];
  logic [31:0] tbd [3];
  logic        mr  [3];
  logic [1:0]  sr  [3];
  logic        mv  [3];
  logic [31:0] md  [3];

  int n_chk = 0;
  int n_err = 0;
  int va [16];
  int vb [16];
  int ve [16];
  int nvec;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mod_adder_pipe_if #(.C_DATA_WIDTH(32), .C_NUM_CHANNELS(2)) bus ();
    mod_adder_pipe #(.P(P), .C_DATA_WIDTH(32), .C_NUM_CHANNELS(2), .LEVEL(g + 1)) dut (
      .aclk(aclk), .areset(areset), .bus(bus));
    assign bus.s_tvalid = tv[g];
    assign bus.s_tdata  = {tbd[g], ta[g]};
    assign bus.m_tready = mr[g];
    assign sr[g] = bus.s_tready;
    assign mv[g] = bus.m_tvalid;
    assign md[g] = bus.m_tdata;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic idle_all();
    for (int i = 0; i < 3; i++) begin
      tv[i] = 2'b00; ta[i] = 0; tbd[i] = 0; mr[i] = 1'b1;
    end
  endtask

  task automatic set_vec(input int i, input int a, input int b, input int e);
    va[i] = a; vb[i] = b; ve[i] = e;
  endtask

  // streams va/vb into DUT idx, checks ve in order; bp toggles m_tready randomly
  task automatic run(input int idx, input bit bp, input string tag);
    int ip, op;
    int acc_cyc [16];
    bit stalled, extra;
    logic [31:0] held;
    ip = 0; op = 0; stalled = 0; extra = 0; held = 0;
    for (int cyc = 0; cyc < 400 && op < nvec; cyc++) begin
      @(negedge aclk);
      mr[idx]  = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      tv[idx]  = (ip < nvec) ? 2'b11 : 2'b00;
      ta[idx]  = (ip < nvec) ? va[ip] : 0;
      tbd[idx] = (ip < nvec) ? vb[ip] : 0;
      #1;
      if (stalled) begin
        check({tag, " hold_valid"}, 32'(mv[idx]), 32'd1);
        check({tag, " hold_data"}, md[idx], held);
      end
      if (mv[idx] && mr[idx]) begin
        check($sformatf("%s out%0d", tag, op), md[idx], 32'(ve[op]));
        if (!bp) check($sformatf("%s latency%0d", tag, op), 32'(cyc - acc_cyc[op]), 32'(idx + 1 + SK));
        op++;
      end
      stalled = mv[idx] && !mr[idx];
      held    = md[idx];
      if (sr[idx][0] && tv[idx][0]) begin
        acc_cyc[ip] = cyc;
        ip++;
      end
    end
    if (op < nvec) check({tag, " timeout"}, 32'(op), 32'(nvec));
    tv[idx] = 2'b00;
    mr[idx] = 1'b1;
    repeat (idx + 4) begin
      @(negedge aclk); #1;
      extra |= mv[idx];
    end
    check({tag, " no_extra"}, 32'(extra), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit seen;
    idle_all();
    repeat (3) @(posedge aclk);
    @(negedge aclk); #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("reset m_tvalid%0d", i), 32'(mv[i]), 32'd0);
      check($sformatf("reset m_tdata%0d", i), md[i], 32'd0);
      check($sformatf("reset s_tready%0d", i), 32'(sr[i]), 32'd0);
    end
    areset = 1'b0;

    nvec = 1;
    set_vec(0, 30, 40, 70);
    run(0, 1'b0, "lvl1");

    nvec = 5;
    set_vec(0, 60, 70, 30);
    set_vec(1, 99, 99, 98);
    set_vec(2, 50, 50, 0);
    set_vec(3, 0, 0, 0);
    set_vec(4, 49, 50, 99);
    run(1, 1'b0, "lvl2");

    seen = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge aclk);
      tv[1] = 2'b01; ta[1] = 10; tbd[1] = 20;
      #1;
      check($sformatf("join lone%0d", c), 32'(sr[1]), 32'd0);
      seen |= mv[1];
    end
    check("join no_output", 32'(seen), 32'd0);
    nvec = 1;
    set_vec(0, 10, 20, 30);
    run(1, 1'b0, "join");

    nvec = 8;
    set_vec(0, 1, 2, 3);
    set_vec(1, 99, 1, 0);
    set_vec(2, 98, 98, 96);
    set_vec(3, 45, 54, 99);
    set_vec(4, 55, 45, 0);
    set_vec(5, 77, 88, 65);
    set_vec(6, 0, 99, 99);
    set_vec(7, 12, 34, 46);
    run(2, 1'b1, "bp");

    @(negedge aclk);
    tv[2] = 2'b11; ta[2] = 3; tbd[2] = 4;
    #1 check("rst accept0", 32'(sr[2]), 32'd3);
    @(negedge aclk);
    ta[2] = 6; tbd[2] = 8;
    #1 check("rst accept1", 32'(sr[2]), 32'd3);
    @(negedge aclk);
    tv[2] = 2'b00; areset = 1'b1;
    @(negedge aclk);
    areset = 1'b0;
    #1;
    check("rst m_tvalid", 32'(mv[2]), 32'd0);
    check("rst m_tdata", md[2], 32'd0);
    seen = 0;
    repeat (6) begin
      @(negedge aclk); #1;
      seen |= mv[2];
    end
    check("rst no_stale", 32'(seen), 32'd0);
    nvec = 1;
    set_vec(0, 5, 7, 12);
    run(2, 1'b0, "post_rst");

`ifdef MOD_ADD_OUT_SKID_EN
    begin : skid_t
      int acc;
      acc = 0;
      mr[1] = 1'b0;
      for (int c = 0; c < 10; c++) begin
        @(negedge aclk);
        tv[1] = 2'b11; ta[1] = 10 + acc; tbd[1] = 20 + acc;
        #1;
        if (sr[1][0]) acc++;
      end
      @(negedge aclk);
      tv[1] = 2'b00;
      check("skid accepted", 32'(acc), 32'd4);
      mr[1] = 1'b1;
      for (int k = 0; k < 4; k++) begin
        #1;
        check($sformatf("skid valid%0d", k), 32'(mv[1]), 32'd1);
        check($sformatf("skid data%0d", k), md[1], 32'(30 + 2 * k));
        @(negedge aclk);
      end
      #1 check("skid drained", 32'(mv[1]), 32'd0);
    end
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
